counter_countdown: RTL

- Loadable down-counter with terminal-count flag. It is the decrementing counterpart of Counter_counter and uses the same ctrl bundle, d/q/load/enable port style and MAX parameter.
- Used for pipeline stall timers, multi-cycle operation countdowns (mul/div latency) and periodic tick generation.
- Counts from a loaded or reload value down to 0, raises a one-cycle done pulse on reaching 0, and optionally auto-reloads.

---
 rtl/counter_pkg.sv | 13 +
 rtl/data_control_pkg.sv | 15 +
 rtl/counter_countdown.sv | 77 +++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Helpers shared by the up and down counters: width derivation and load-value saturation.
package counter_pkg;

    function automatic int unsigned counter_width(input int unsigned max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

    function automatic logic [31:0] counter_saturate(input logic [31:0] value,
                                                     input logic [31:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/data_control_pkg.sv
// Shared clock/reset bundle type and the accessor macros every block uses to reach into it.
`ifndef DATA_CONTROL_MACROS
`define DATA_CONTROL_MACROS
`define Data_Control_Clock(c) c.clk
`define Data_Control_Reset(c) c.rst
`endif

package data_control_pkg;

    typedef struct packed {
        logic clk;
        logic rst;
    } Data_Control_T;

endpackage

// File: rtl/counter_countdown.sv
// Loadable down-counter: counts a loaded value to zero and emits a one-cycle done pulse,
// optionally reloading from the last loaded period.
module counter_countdown
    import data_control_pkg::*;
    import counter_pkg::*;
#(
    parameter int unsigned MAX         = 12,
    parameter int unsigned WIDTH       = counter_width(MAX),
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  Data_Control_T    ctrl,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic             enable,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             done,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_period;
    logic             r_zero;
    logic             r_done;
    logic             r_busy;

    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_period_next;
    logic             w_done_next;
    logic [WIDTH-1:0] w_load_sat;

    assign w_load_sat = WIDTH'(counter_saturate(32'(d), 32'(MaxVal)));

    always_comb begin
        w_q_next      = r_q;
        w_period_next = r_period;
        w_done_next   = 1'b0;
        if (load) begin
            w_q_next      = w_load_sat;
            w_period_next = w_load_sat;
        end else if (enable) begin
            if (r_q > WIDTH'(1)) begin
                w_q_next = r_q - WIDTH'(1);
            end else if (r_q == WIDTH'(1)) begin
                w_q_next    = '0;
                w_done_next = 1'b1;
            end else if (AUTO_RELOAD) begin
                // Reloading a zero period leaves q at 0 and never re-pulses done.
                w_q_next = r_period;
            end
        end
    end

    always_ff @(posedge `Data_Control_Clock(ctrl)) begin
        if (`Data_Control_Reset(ctrl)) begin
            r_q      <= '0;
            r_period <= '0;
            r_zero   <= 1'b1;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_q      <= w_q_next;
            r_period <= w_period_next;
            r_zero   <= (w_q_next == '0);
            r_done   <= w_done_next;
            r_busy   <= (w_q_next != '0);
        end
    end

    assign q    = r_q;
    assign zero = r_zero;
    assign done = r_done;
    assign busy = r_busy;

endmodule
